// File: rtl/vga_tile_pkg.sv
// Shared constants and types for the tile RAM arbiter: screen geometry,
// tile codes, the clear FSM state and the internal grant selector.
package vga_tile_pkg;

    localparam int TILE_PX    = 20;
    localparam int GRID_W     = 32;
    localparam int GRID_H     = 24;
    localparam int TILE_COUNT = GRID_W * GRID_H;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BODY  = 2'd1,
        HEAD  = 2'd2,
        FOOD  = 2'd3
    } tile_code_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    typedef enum logic {
        RR_WR = 1'b0,
        RR_RD = 1'b1
    } rr_sel_t;

    typedef enum logic [2:0] {
        GNT_NONE = 3'd0,
        GNT_VID  = 3'd1,
        GNT_CLR  = 3'd2,
        GNT_WR   = 3'd3,
        GNT_RD   = 3'd4
    } gnt_src_t;

endpackage

// File: rtl/vga_blank_window.sv
// Tracks the vertical blank window in which game writes may land: it opens on
// the vsync falling edge (frame_tick) and closes on the activevideo rising edge.
module vga_blank_window (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic activevideo,
    output logic frame_tick,
    output logic window_open
);

    logic vsync_q, vsync_d;
    logic active_q, active_d;
    logic open_q, open_d;
    logic vsync_fall;
    logic active_rise;

    // The window flag is used in the very cycle an edge is seen, so the
    // arbiter consumes the next-state value rather than the register.
    always_comb begin
        vsync_d     = vsync;
        active_d    = activevideo;
        vsync_fall  = vsync_q & ~vsync;
        active_rise = ~active_q & activevideo;
        open_d      = open_q;
        if (active_rise) begin
            open_d = 1'b0;
        end else if (vsync_fall) begin
            open_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q  <= 1'b1;
            active_q <= 1'b1;
            open_q   <= 1'b0;
        end else begin
            vsync_q  <= vsync_d;
            active_q <= active_d;
            open_q   <= open_d;
        end
    end

    assign frame_tick  = vsync_fall & ~rst;
    assign window_open = open_d & ~rst;

endmodule

// File: rtl/vga_tile_arbiter.sv
// Single-port tile RAM arbiter: renderer reads always win, then the full-RAM
// clear, then round-robin between game writes and reads.
module vga_tile_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 2,
    parameter int TILE_COUNT = 768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              activevideo,
    input  logic              sync_wr_en,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_req,
    output logic              clr_done,
    output logic              busy,
    output logic              oor,
    output logic              frame_tick,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import vga_tile_pkg::*;

    localparam logic [ADDR_W:0]   TILE_LIMIT = (ADDR_W + 1)'(TILE_COUNT);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TILE_COUNT - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    rr_sel_t           rr_q, rr_d;
    logic              vid_valid_q, vid_valid_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    gnt_src_t gnt;
    logic     window_open;
    logic     in_clear;
    logic     wr_elig;
    logic     rd_elig;
    logic     wr_in_range;

    vga_blank_window u_blank_window (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .activevideo (activevideo),
        .frame_tick  (frame_tick),
        .window_open (window_open)
    );

    assign in_clear    = (state_q == CLEAR);
    assign wr_in_range = ({1'b0, wr_addr} < TILE_LIMIT);
    assign wr_elig     = wr_req & ~in_clear & (~sync_wr_en | window_open);
    assign rd_elig     = rd_req & ~in_clear;

    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (vid_req) begin
                gnt = GNT_VID;
            end else if (in_clear) begin
                gnt = GNT_CLR;
            end else if (wr_elig && rd_elig) begin
                gnt = (rr_q == RR_WR) ? GNT_WR : GNT_RD;
            end else if (wr_elig) begin
                gnt = GNT_WR;
            end else if (rd_elig) begin
                gnt = GNT_RD;
            end
        end
    end

    // An out-of-range write is still acknowledged so the game never stalls on it.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        oor       = 1'b0;
        case (gnt)
            GNT_VID: begin
                ram_addr = vid_addr;
            end
            GNT_CLR: begin
                ram_addr  = clr_addr_q;
                ram_we    = 1'b1;
                ram_wdata = DATA_W'(EMPTY);
            end
            GNT_WR: begin
                wr_gnt   = 1'b1;
                ram_addr = wr_addr;
                if (wr_in_range) begin
                    ram_we    = 1'b1;
                    ram_wdata = wr_data;
                end else begin
                    oor = 1'b1;
                end
            end
            GNT_RD: begin
                rd_gnt   = 1'b1;
                ram_addr = rd_addr;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        rr_d        = rr_q;
        vid_valid_d = (gnt == GNT_VID);
        rd_valid_d  = (gnt == GNT_RD);
        rd_data_d   = rd_valid_q ? ram_rdata : rd_data_q;

        case (state_q)
            IDLE: begin
                clr_addr_d = '0;
                if (clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (gnt == GNT_CLR) begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (gnt == GNT_WR) begin
            rr_d = RR_RD;
        end else if (gnt == GNT_RD) begin
            rr_d = RR_WR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            rr_q        <= RR_WR;
            vid_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            rr_q        <= rr_d;
            vid_valid_q <= vid_valid_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // rd_data is captured from ram_rdata during the rd_valid cycle and held.
    assign vid_valid = vid_valid_q & ~rst;
    assign rd_valid  = rd_valid_q & ~rst;
    assign rd_data   = rd_data_q & {DATA_W{~rst}};
    assign busy      = in_clear & ~rst;
    assign clr_done  = (state_q == DONE) & ~rst;

endmodule
